// File: rtl/kbd_key_tracker_pkg.sv
// Shared definitions for the PS/2 Set-2 key tracker: FSM states,
// prefix/control byte values and the table of game keys.
package kbd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_EXT     = 3'd1,
      ST_BRK     = 3'd2,
      ST_EXT_BRK = 3'd3,
      ST_PAUSE   = 3'd4
   } kbd_state_t;

   // Prefix bytes
   localparam logic [7:0] BYTE_E0 = 8'hE0;
   localparam logic [7:0] BYTE_F0 = 8'hF0;
   localparam logic [7:0] BYTE_E1 = 8'hE1;

   // Keyboard replies (ack, self-test pass, echo, resend, overrun/errors)
   localparam logic [7:0] BYTE_FA = 8'hFA;
   localparam logic [7:0] BYTE_AA = 8'hAA;
   localparam logic [7:0] BYTE_EE = 8'hEE;
   localparam logic [7:0] BYTE_FE = 8'hFE;
   localparam logic [7:0] BYTE_00 = 8'h00;
   localparam logic [7:0] BYTE_FF = 8'hFF;

   // Bytes following E1 that are swallowed without decoding
   localparam logic [2:0] PAUSE_SKIP = 3'd7;

   // Key table: {extended, code}
   localparam int KEY_COUNT = 8;
   localparam int KEY_W     = 0;
   localparam int KEY_S     = 1;
   localparam int KEY_UP    = 2;
   localparam int KEY_DOWN  = 3;
   localparam int KEY_SPACE = 4;
   localparam int KEY_ENTER = 5;
   localparam int KEY_P     = 6;
   localparam int KEY_ESC   = 7;

   localparam logic [8:0] KEY_TABLE [KEY_COUNT] = '{
      9'h01D,  // W
      9'h01B,  // S
      9'h175,  // Up
      9'h172,  // Down
      9'h029,  // Space
      9'h05A,  // Enter
      9'h04D,  // P
      9'h076   // Esc
   };

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == BYTE_E0) || (b == BYTE_F0) || (b == BYTE_E1);
   endfunction

   function automatic logic is_ignored(input logic [7:0] b);
      return (b == BYTE_FA) || (b == BYTE_AA) || (b == BYTE_EE) ||
             (b == BYTE_FE) || (b == BYTE_00) || (b == BYTE_FF);
   endfunction

endpackage

// File: rtl/kbd_key_tracker_if.sv
// Byte stream from the PS/2 receiver plus the decoded key outputs.
//
// Handshake: din_new is a one-cycle strobe qualifying din; there is no
// ready/backpressure, the tracker accepts a byte on every cycle that
// din_new is high, including consecutive cycles.
interface kbd_key_tracker_if #(
   parameter int NUM_KEYS = 8
);
   logic [7:0]          din;
   logic                din_new;
   logic [NUM_KEYS-1:0] key_pressed;
   logic                key_event;
   logic [8:0]          key_code;
   logic                key_make;
   logic                seq_error;

   // Byte source / key consumer side
   modport master (
      output din, din_new,
      input  key_pressed, key_event, key_code, key_make, seq_error
   );

   // Tracker side
   modport slave (
      input  din, din_new,
      output key_pressed, key_event, key_code, key_make, seq_error
   );
endinterface

// File: rtl/kbd_key_tracker_lookup.sv
// Combinational match of a 9-bit {extended, code} against the key table.
module kbd_key_lookup
   import kbd_pkg::*;
(
   input  logic [8:0] code,
   output logic       hit,
   output logic [2:0] idx
);

   // Linear search; table entries are unique so at most one hits
   always_comb begin
      hit = 1'b0;
      idx = 3'd0;
      for (int k = 0; k < KEY_COUNT; k++) begin
         if (code == KEY_TABLE[k]) begin
            hit = 1'b1;
            idx = 3'(k);
         end
      end
   end

endmodule

// File: rtl/kbd_key_tracker.sv
// Set-2 scan-code sequencer: turns the receiver byte stream into make/break
// events and a held-key bitmap for the game keys. All outputs registered.
module kbd_key_tracker
   import kbd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 2_500_000,
   parameter int NUM_KEYS       = 8
) (
   input  logic             clk,
   input  logic             reset,
   kbd_key_tracker_if.slave bus,
   output kbd_state_t       dbg_state
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   kbd_state_t          state;
   logic [TW-1:0]       to_cnt;
   logic [2:0]          skip_cnt;
   logic [NUM_KEYS-1:0] key_pressed;
   logic                key_event;
   logic [8:0]          key_code;
   logic                key_make;
   logic                seq_error;

   // The extended flag of the code being decoded comes from the state
   logic       dec_ext;
   logic [8:0] dec_code;
   logic       lk_hit;
   logic [2:0] lk_idx;

   assign dec_ext  = (state == ST_EXT) || (state == ST_EXT_BRK);
   assign dec_code = {dec_ext, bus.din};

   kbd_key_lookup u_lookup (
      .code (dec_code),
      .hit  (lk_hit),
      .idx  (lk_idx)
   );

   // Sequencer FSM with inter-byte timeout; a byte always beats the timeout
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         to_cnt      <= '0;
         skip_cnt    <= '0;
         key_pressed <= '0;
         key_event   <= 1'b0;
         key_code    <= '0;
         key_make    <= 1'b0;
         seq_error   <= 1'b0;
      end else begin
         key_event <= 1'b0;
         seq_error <= 1'b0;

         if (state == ST_IDLE || bus.din_new) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (bus.din_new) begin
            case (state)
               ST_IDLE: begin
                  if (bus.din == BYTE_E0) begin
                     state <= ST_EXT;
                  end else if (bus.din == BYTE_F0) begin
                     state <= ST_BRK;
                  end else if (bus.din == BYTE_E1) begin
                     state    <= ST_PAUSE;
                     skip_cnt <= PAUSE_SKIP;
                  end else if (!is_ignored(bus.din)) begin
                     key_event <= 1'b1;
                     key_code  <= dec_code;
                     key_make  <= 1'b1;
                     if (lk_hit) key_pressed[lk_idx] <= 1'b1;
                  end
               end
               ST_EXT: begin
                  if (bus.din == BYTE_F0) begin
                     state <= ST_EXT_BRK;
                  end else if (is_prefix(bus.din)) begin
                     seq_error <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     key_event <= 1'b1;
                     key_code  <= dec_code;
                     key_make  <= 1'b1;
                     if (lk_hit) key_pressed[lk_idx] <= 1'b1;
                     state     <= ST_IDLE;
                  end
               end
               ST_BRK, ST_EXT_BRK: begin
                  if (is_prefix(bus.din)) begin
                     seq_error <= 1'b1;
                  end else begin
                     key_event <= 1'b1;
                     key_code  <= dec_code;
                     key_make  <= 1'b0;
                     if (lk_hit) key_pressed[lk_idx] <= 1'b0;
                  end
                  state <= ST_IDLE;
               end
               ST_PAUSE: begin
                  if (skip_cnt <= 3'd1) begin
                     skip_cnt <= '0;
                     state    <= ST_IDLE;
                  end else begin
                     skip_cnt <= skip_cnt - 3'd1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end else if (state != ST_IDLE && to_cnt == TO_LAST) begin
            seq_error <= 1'b1;
            state     <= ST_IDLE;
            skip_cnt  <= '0;
            to_cnt    <= '0;
         end
      end
   end

   assign bus.key_pressed = key_pressed;
   assign bus.key_event   = key_event;
   assign bus.key_code    = key_code;
   assign bus.key_make    = key_make;
   assign bus.seq_error   = seq_error;
   assign dbg_state       = state;

endmodule
